// File: rtl/coloring_fb_stage.sv
// coloring_fb_stage: final rendering stage. Writes pixel colours into an
// on-chip framebuffer and, after NUM_TRIANGLES triangles, streams the whole
// buffer out four pixels per word, clearing each word as it is read.
// Optional build macro: COLORING_FB_PERF_EN adds the pix_written/pix_dropped
// per-frame pixel counters.
module coloring_fb_stage #(
    parameter int unsigned FB_W_BITS     = 8,
    parameter int unsigned FB_H_BITS     = 8,
    parameter int unsigned NUM_TRIANGLES = 3192,
    parameter int unsigned CNT_BITS      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Input_1_V_TDATA,
    input  logic        Input_1_V_TVALID,
    output logic        Input_1_V_TREADY,
    output logic [31:0] Output_1_V_TDATA,
    output logic        Output_1_V_TVALID,
    input  logic        Output_1_V_TREADY,
    output logic        frame_done
`ifdef COLORING_FB_PERF_EN
    ,
    output logic [31:0] pix_written,
    output logic [31:0] pix_dropped
`endif
);

    localparam int unsigned AW        = FB_W_BITS + FB_H_BITS - 2;
    localparam int unsigned DEPTH     = 1 << AW;
    localparam int unsigned XW        = (FB_W_BITS > 8) ? FB_W_BITS : 8;
    localparam int unsigned YW        = (FB_H_BITS > 8) ? FB_H_BITS : 8;
    localparam logic [31:0] X_LIM     = 32'(1) << FB_W_BITS;
    localparam logic [31:0] Y_LIM     = 32'(1) << FB_H_BITS;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CNT_BITS-1:0] TRI_LAST = CNT_BITS'(NUM_TRIANGLES);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_HDR,
        S_PIX,
        S_RD,
        S_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [CNT_BITS-1:0] tri_q, tri_d;
    logic [CNT_BITS-1:0] tri_inc;
    logic [15:0]         n_q, n_d;
    logic [15:0]         pix_q, pix_d;
    logic                done_d;
    logic                tri_done;
    logic                wr_px;
    logic                drop_px;

    // Framebuffer write/read port controls
    logic                mem_we;
    logic [3:0]          mem_be;
    logic [AW-1:0]       mem_waddr;
    logic [31:0]         mem_wdata;
    logic                mem_re;
    logic [31:0]         mem [DEPTH];

    // Pixel field decode
    logic [XW-1:0]       px_x;
    logic [YW-1:0]       px_y;
    logic [7:0]          px_colour;
    logic                px_in_range;
    logic [AW-1:0]       px_addr;
    logic [1:0]          px_lane;
    logic                in_xfer;
    logic                out_xfer;
    logic                unused_ok;

    // Split the incoming word into pixel fields and framebuffer location
    always_comb begin
        px_x        = XW'(Input_1_V_TDATA[7:0]);
        px_y        = YW'(Input_1_V_TDATA[15:8]);
        px_colour   = Input_1_V_TDATA[23:16];
        px_in_range = (32'(px_x) < X_LIM) && (32'(px_y) < Y_LIM);
        px_addr     = {px_y[FB_H_BITS-1:0], px_x[FB_W_BITS-1:2]};
        px_lane     = px_x[1:0];
        in_xfer     = Input_1_V_TVALID && Input_1_V_TREADY;
        out_xfer    = Output_1_V_TVALID && Output_1_V_TREADY;
        tri_inc     = tri_q + CNT_BITS'(1);
    end

    assign unused_ok = &{1'b0, Input_1_V_TDATA[31:24]};

    // Next-state, counters and framebuffer port control
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        tri_d     = tri_q;
        n_d       = n_q;
        pix_d     = pix_q;
        done_d    = 1'b0;
        tri_done  = 1'b0;
        wr_px     = 1'b0;
        drop_px   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_waddr = addr_q;
        mem_wdata = 32'h0;
        mem_re    = 1'b0;

        case (state_q)
            S_CLEAR: begin
                mem_we = 1'b1;
                mem_be = 4'hF;
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = S_HDR;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            S_HDR: begin
                if (in_xfer) begin
                    n_d   = Input_1_V_TDATA[15:0];
                    pix_d = 16'h0;
                    if (Input_1_V_TDATA[15:0] == 16'h0) begin
                        tri_done = 1'b1;
                    end else begin
                        state_d = S_PIX;
                    end
                end
            end
            S_PIX: begin
                if (in_xfer) begin
                    pix_d = pix_q + 16'd1;
                    if (px_in_range) begin
                        mem_we    = 1'b1;
                        mem_be    = 4'b0001 << px_lane;
                        mem_waddr = px_addr;
                        mem_wdata = {4{px_colour}};
                        wr_px     = 1'b1;
                    end else begin
                        drop_px = 1'b1;
                    end
                    if ((pix_q + 16'd1) == n_q) begin
                        tri_done = 1'b1;
                    end
                end
            end
            S_RD: begin
                mem_re  = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_xfer) begin
                    // Clear-on-read leaves the buffer zeroed for the next frame
                    mem_we = 1'b1;
                    mem_be = 4'hF;
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = S_HDR;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        state_d = S_RD;
                    end
                end
            end
            default: begin
                state_d = S_CLEAR;
                addr_d  = '0;
            end
        endcase

        // Triangle bookkeeping; the last triangle of a frame starts readout
        if (tri_done) begin
            if (tri_inc == TRI_LAST) begin
                tri_d   = '0;
                addr_d  = '0;
                state_d = S_RD;
            end else begin
                tri_d   = tri_inc;
                state_d = S_HDR;
            end
        end
    end

    // State register and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_CLEAR;
            addr_q            <= '0;
            tri_q             <= '0;
            n_q               <= 16'h0;
            pix_q             <= 16'h0;
            Input_1_V_TREADY  <= 1'b0;
            Output_1_V_TVALID <= 1'b0;
            frame_done        <= 1'b0;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            tri_q             <= tri_d;
            n_q               <= n_d;
            pix_q             <= pix_d;
            Input_1_V_TREADY  <= (state_d == S_HDR) || (state_d == S_PIX);
            Output_1_V_TVALID <= (state_d == S_OUT);
            frame_done        <= done_d;
        end
    end

    // Framebuffer storage with per-byte write enables
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_be[k]) begin
                    mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

    // One-cycle read into the output data register; held until the next read
    always_ff @(posedge clk) begin
        if (reset) begin
            Output_1_V_TDATA <= 32'h0;
        end else if (mem_re) begin
            Output_1_V_TDATA <= mem[addr_q];
        end
    end

`ifdef COLORING_FB_PERF_EN
    // Per-frame pixel counters, cleared once the frame has been handed off
    always_ff @(posedge clk) begin
        if (reset || frame_done) begin
            pix_written <= 32'h0;
            pix_dropped <= 32'h0;
        end else begin
            if (wr_px) begin
                pix_written <= pix_written + 32'd1;
            end
            if (drop_px) begin
                pix_dropped <= pix_dropped + 32'd1;
            end
        end
    end
`endif

endmodule
